// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide engine.
//
// Multiply is shift-add and divide is restoring, both retiring one bit per
// cycle. Operands are reduced to magnitudes at accept. A final FIX cycle
// applies the sign negation and the result selection. Divide-by-zero and
// signed overflow (MIN / -1) skip the iteration and go straight to DONE.
//
// Optional build macro:
//   MULDIV_FAST_MUL_EN  ops 0-3 use one combinational multiply latched at
//                       accept (IDLE->DONE in one edge). Results match the
//                       iterative build bit for bit.
//
// Ports:
//   clk_In      in   1     clock, rising edge
//   rst_In      in   1     asynchronous active-high reset
//   start_In    in   1     request, sampled while ready_Out=1
//   op_In       in   3     funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   opA_In      in   XLEN  rs1 (multiplicand / dividend)
//   opB_In      in   XLEN  rs2 (multiplier / divisor)
//   kill_In     in   1     flush; aborts the in-flight op, blocks accept
//   ready_Out   out  1     start can be accepted this cycle (IDLE|DONE)
//   busy_Out    out  1     iteration in progress (MUL|DIV|FIX)
//   done_Out    out  1     one-cycle pulse, result_Out valid
//   result_Out  out  XLEN  result, held until overwritten by a later op
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk_In,
    input  logic            rst_In,
    input  logic            start_In,
    input  logic [2:0]      op_In,
    input  logic [XLEN-1:0] opA_In,
    input  logic [XLEN-1:0] opB_In,
    input  logic            kill_In,
    output logic            ready_Out,
    output logic            busy_Out,
    output logic            done_Out,
    output logic [XLEN-1:0] result_Out
);

    localparam int unsigned       W2   = 2 * XLEN;
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       op_q;
    logic             sa_q, sb_q;
    logic [XLEN-1:0]  b_q;
    // Multiply: full product accumulator {hi, lo}.
    // Divide:   {remainder, quotient/dividend shift register}.
    logic [W2-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  result_q;

    // ---------------- accept-time decode ----------------
    logic            a_signed, b_signed, sa_in, sb_in, accept;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            byp_hit;
    logic [XLEN-1:0] byp_val;

    always_comb begin
        a_signed = (op_In == 3'd1) || (op_In == 3'd2) || (op_In == 3'd4) || (op_In == 3'd6);
        b_signed = (op_In == 3'd1) || (op_In == 3'd4) || (op_In == 3'd6);
        sa_in    = a_signed & opA_In[XLEN-1];
        sb_in    = b_signed & opB_In[XLEN-1];
        a_mag_in = sa_in ? (~opA_In + 1'b1) : opA_In;
        b_mag_in = sb_in ? (~opB_In + 1'b1) : opB_In;
        accept   = start_In & ready_Out & ~kill_In;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [W2-1:0] fast_prod, fast_full;
`endif

    always_comb begin
        byp_hit = 1'b0;
        byp_val = '0;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{XLEN{1'b0}}, a_mag_in} * {{XLEN{1'b0}}, b_mag_in};
        fast_full = (sa_in ^ sb_in) ? (~fast_prod + 1'b1) : fast_prod;
`endif
        if (op_In[2] && (opB_In == '0)) begin
            byp_hit = 1'b1;
            byp_val = op_In[1] ? opA_In : '1;
        end else if (op_In[2] && !op_In[0] && (opA_In == MIN) && (opB_In == '1)) begin
            byp_hit = 1'b1;
            byp_val = op_In[1] ? '0 : MIN;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!op_In[2]) begin
            byp_hit = 1'b1;
            byp_val = (op_In == 3'd0) ? fast_full[XLEN-1:0] : fast_full[W2-1:XLEN];
        end
`endif
    end

    // ---------------- iteration steps ----------------
    logic [XLEN:0]   mul_sum;
    logic [W2-1:0]   mul_next;
    logic [XLEN:0]   div_shift, div_sub;
    logic            div_take;
    logic [W2-1:0]   div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc[XLEN-1:1]};

        div_shift = {acc[W2-1:XLEN], acc[XLEN-1]};
        div_sub   = div_shift - {1'b0, b_q};
        // A set remainder MSB means the shifted value is >= 2^XLEN > divisor,
        // otherwise the XLEN+1-bit subtract's sign bit is the borrow.
        div_take  = acc[W2-1] | ~div_sub[XLEN];
        div_next  = {(div_take ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc[XLEN-2:0], div_take};
    end

    // ---------------- sign fix-up ----------------
    logic [W2-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_val;

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? (~acc + 1'b1) : acc;
        quo_fix  = (sa_q ^ sb_q) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_fix  = sa_q ? (~acc[W2-1:XLEN] + 1'b1) : acc[W2-1:XLEN];
        case (op_q)
            3'd0:                fix_val = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_val = prod_fix[W2-1:XLEN];
            3'd4, 3'd5:          fix_val = quo_fix;
            default:             fix_val = rem_fix;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_In or posedge rst_In) begin
        if (rst_In) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_Out = 1'b0;
        busy_Out  = 1'b0;
        done_Out  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                ready_Out = 1'b1;
                done_Out  = (state == S_DONE);
                state_nxt = S_IDLE;
                if (accept) begin
                    if (byp_hit)       state_nxt = S_DONE;
                    else if (op_In[2]) state_nxt = S_DIV;
                    else               state_nxt = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                busy_Out = 1'b1;
                if (cnt == LAST) state_nxt = S_FIX;
            end
            S_FIX: begin
                busy_Out  = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (kill_In) state_nxt = S_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_In or posedge rst_In) begin
        if (rst_In) begin
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            b_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q <= op_In;
            sa_q <= sa_in;
            sb_q <= sb_in;
            b_q  <= b_mag_in;
            acc  <= {{XLEN{1'b0}}, a_mag_in};
            cnt  <= '0;
            if (byp_hit) result_q <= byp_val;
        end else begin
            case (state)
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!kill_In) result_q <= fix_val;
                end
                default: ;
            endcase
        end
    end

    assign result_Out = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32).
// Latency is counted in rising edges from the accept edge (inclusive) up to
// the edge after which done_Out is first seen high.
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif
    localparam int DIV_LAT = XLEN + 2;
    localparam int BYP_LAT = 1;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            start = 1'b0;
    logic            kill  = 1'b0;
    logic [2:0]      op    = '0;
    logic [XLEN-1:0] a     = '0;
    logic [XLEN-1:0] b     = '0;
    logic            ready, busy, done;
    logic [XLEN-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0] last_res = '0;

    muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk_In    (clk),
        .rst_In    (rst),
        .start_In  (start),
        .op_In     (op),
        .opA_In    (a),
        .opB_In    (b),
        .kill_In   (kill),
        .ready_Out (ready),
        .busy_Out  (busy),
        .done_Out  (done),
        .result_Out(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request before an edge; returns 1 ns after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int lat_exp);
        int lat;
        issue(o, x, y);
        wait_done(1, lat);
        check({tag, "_done"}, 32'(done), 32'd1);
        check(tag, result, exp);
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        last_res = exp;
    endtask

    initial begin
        int lat;
        int n_done;

        #2 rst = 1'b1;
        #1;
        check("rst_ready",  32'(ready), 32'd1);
        check("rst_busy",   32'(busy),  32'd0);
        check("rst_done",   32'(done),  32'd0);
        check("rst_result", result,     32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Multiply family
        run("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);

        // Divide family
        run("div",    3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT);
        run("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_LAT);
        run("divu",   3'd5, 32'd100,      32'd7, 32'd14,       DIV_LAT);
        run("remu",   3'd7, 32'd100,      32'd7, 32'd2,        DIV_LAT);

        // Bypass cases
        run("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, BYP_LAT);
        run("rem_z",  3'd6, 32'd5, 32'd0, 32'd5,        BYP_LAT);
        run("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, BYP_LAT);
        run("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        BYP_LAT);

        // Kill at iteration 10 of a DIV
        issue(3'd4, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk) kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_ready",  32'(ready), 32'd1);
        check("kill_busy",   32'(busy),  32'd0);
        check("kill_done",   32'(done),  32'd0);
        check("kill_result", result,     last_res);
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("kill_no_done", 32'(n_done), 32'd0);
        run("mul_after_kill", 3'd0, 32'd3, 32'd4, 32'd12, MUL_LAT);

        // kill together with start: nothing accepted
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 3'd5; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("killstart_busy",  32'(busy),  32'd0);
        check("killstart_ready", 32'(ready), 32'd1);
        n_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("killstart_no_done", 32'(n_done), 32'd0);
        check("killstart_result",  result,      last_res);

        // start while busy is ignored
        issue(3'd5, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_ign_busy", 32'(busy), 32'd1);
        wait_done(5, lat);
        check("busy_ign_done",   32'(done), 32'd1);
        check("busy_ign_result", result,    32'd14);
        check("busy_ign_lat",    32'(lat),  32'(DIV_LAT));
        @(posedge clk); #1;
        check("busy_ign_pulse",  32'(done), 32'd0);

        // Back-to-back: new start accepted in the DONE cycle
        issue(3'd7, 32'd100, 32'd7);
        wait_done(1, lat);
        check("b2b_first_done",   32'(done), 32'd1);
        check("b2b_first_result", result,    32'd2);
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy | done), 32'd1);
        wait_done(1, lat);
        check("b2b_done",   32'(done), 32'd1);
        check("b2b_result", result,    32'd42);
        check("b2b_lat",    32'(lat),  32'(MUL_LAT));
        @(posedge clk); #1;

        // Asynchronous reset mid-MUL (result register holds 42 beforehand)
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_ready",  32'(ready), 32'd1);
        check("arst_busy",   32'(busy),  32'd0);
        check("arst_done",   32'(done),  32'd0);
        check("arst_result", result,     32'd0);
        @(negedge clk) rst = 1'b0;
        run("mulhu_after_rst", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
